// File: rtl/snake_state_sink.sv
// Receive side of the snake-state writeback port: shadow-buffers slot writes and
// publishes the whole snake at the next frame boundary after a commit.
module snake_state_sink #(
   parameter logic [31:0] BASE_ADDR = 32'd1000,
   parameter int unsigned NUM_WORDS = 12,
   parameter int unsigned WORD_W    = 30,
   localparam int unsigned SNAKE_W  = NUM_WORDS * WORD_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               isLoadSnake_w,
   input  logic [31:0]        o_mw,
   input  logic [31:0]        d_mw,
   input  logic               frame_start,
   output logic [SNAKE_W-1:0] snake,
   output logic               commit_pending,
   output logic               overrun,
   output logic               addr_error,
   output logic [15:0]        frame_count
);

   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic {
      ACCUM   = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WORD_W-1:0] shadow [NUM_WORDS];
   logic [31:0]       off;
   logic              is_slot;
   logic              is_commit;
   logic              is_bad;
   logic              shadow_we;
   logic              overrun_set;
   logic              copy_en;
   logic              unused_d_hi;

   // Address decode; every case is qualified by the writeback strobe.
   assign off         = o_mw - BASE_ADDR;
   assign is_slot     = isLoadSnake_w && (off < 32'(NUM_WORDS));
   assign is_commit   = isLoadSnake_w && (off == 32'(NUM_WORDS));
   assign is_bad      = isLoadSnake_w && (off > 32'(NUM_WORDS));
   assign unused_d_hi = ^d_mw[31:WORD_W];

   always_ff @(posedge clock) begin
      if (reset) state <= ACCUM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (is_commit)   state_nxt = PENDING;
         PENDING: if (frame_start) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Datapath strobes; a commit arriving in PENDING is deliberately ignored.
   always_comb begin
      shadow_we   = 1'b0;
      overrun_set = 1'b0;
      copy_en     = 1'b0;
      case (state)
         ACCUM:   shadow_we = is_slot;
         PENDING: begin
            overrun_set = is_slot;
            copy_en     = frame_start;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
      end else if (shadow_we) begin
         shadow[IDX_W'(off)] <= d_mw[WORD_W-1:0];
      end
   end

   // Whole-vector copy in one edge so the renderer never sees a torn snake.
   always_ff @(posedge clock) begin
      if (reset) begin
         snake       <= '0;
         frame_count <= '0;
      end else if (copy_en) begin
         for (int k = 0; k < NUM_WORDS; k++) snake[k*WORD_W +: WORD_W] <= shadow[k];
         frame_count <= frame_count + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         overrun    <= 1'b0;
         addr_error <= 1'b0;
      end else begin
         if (overrun_set) overrun    <= 1'b1;
         if (is_bad)      addr_error <= 1'b1;
      end
   end

   assign commit_pending = (state == PENDING);

endmodule

// File: tb/tb_snake_state_sink.sv
// Directed bench for snake_state_sink: spec-level model plus a queue of expected
// frame publications compared when the DUT copies the shadow buffer.
module tb_snake_state_sink;

   localparam int unsigned NW  = 12;
   localparam int unsigned WW  = 30;
   localparam int unsigned SW  = NW * WW;
   localparam logic [31:0] BASE = 32'd1000;

   logic          clock = 1'b0;
   logic          reset;
   logic          isLoadSnake_w;
   logic [31:0]   o_mw;
   logic [31:0]   d_mw;
   logic          frame_start;
   logic [SW-1:0] snake;
   logic          commit_pending;
   logic          overrun;
   logic          addr_error;
   logic [15:0]   frame_count;

   typedef struct {
      logic [SW-1:0] snake;
      logic [15:0]   fc;
   } exp_t;

   exp_t          exp_q [$];
   logic [WW-1:0] m_shadow [NW];
   logic [SW-1:0] m_snake;
   logic          m_pending;
   logic          m_overrun;
   logic          m_adderr;
   logic [15:0]   m_fc;
   int            n_cmp  = 0;
   int            n_fail = 0;

   snake_state_sink dut (
      .clock          (clock),
      .reset          (reset),
      .isLoadSnake_w  (isLoadSnake_w),
      .o_mw           (o_mw),
      .d_mw           (d_mw),
      .frame_start    (frame_start),
      .snake          (snake),
      .commit_pending (commit_pending),
      .overrun        (overrun),
      .addr_error     (addr_error),
      .frame_count    (frame_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("snake", SW'(snake), m_snake);
      check("frame_count", SW'(frame_count), SW'(m_fc));
      check("commit_pending", SW'(commit_pending), SW'(m_pending));
      check("overrun", SW'(overrun), SW'(m_overrun));
      check("addr_error", SW'(addr_error), SW'(m_adderr));
   endtask

   task automatic model_reset();
      for (int k = 0; k < NW; k++) m_shadow[k] = '0;
      m_snake   = '0;
      m_pending = 1'b0;
      m_overrun = 1'b0;
      m_adderr  = 1'b0;
      m_fc      = '0;
      exp_q.delete();
   endtask

   // One clock of stimulus: model the cycle, then compare after the edge.
   task automatic step(input logic s, input logic [31:0] a, input logic [31:0] d, input logic fs);
      logic [31:0] off;
      logic        commit;
      exp_t        e;
      exp_t        got;
      isLoadSnake_w = s;
      o_mw          = a;
      d_mw          = d;
      frame_start   = fs;
      off    = a - BASE;
      commit = 1'b0;
      if (s) begin
         if (off < 32'(NW)) begin
            if (m_pending) m_overrun = 1'b1;
            else           m_shadow[off[3:0]] = d[WW-1:0];
         end else if (off == 32'(NW)) begin
            commit = 1'b1;
         end else begin
            m_adderr = 1'b1;
         end
      end
      if (m_pending && fs) begin
         for (int k = 0; k < NW; k++) m_snake[k*WW +: WW] = m_shadow[k];
         m_fc      = m_fc + 16'd1;
         m_pending = 1'b0;
         e.snake   = m_snake;
         e.fc      = m_fc;
         exp_q.push_back(e);
      end else if (!m_pending && commit) begin
         m_pending = 1'b1;
      end
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         check("frame_snake", SW'(snake), got.snake);
         check("frame_fc", SW'(frame_count), SW'(got.fc));
      end
      check_state();
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      isLoadSnake_w = 1'b0;
      o_mw          = '0;
      d_mw          = '0;
      frame_start   = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_state();
   endtask

   initial begin
      logic [31:0]   slot_exp;
      logic [SW-1:0] snap;

      // 1: reset state, from an uninitialised design
      do_reset();
      idle();

      // 2: fill every slot, commit, publish on frame_start
      for (int k = 0; k < NW; k++) step(1'b1, BASE + 32'(k), 32'h3000_0000 + 32'(k), 1'b0);
      step(1'b1, 32'd1012, 32'hDEAD_BEEF, 1'b0);
      check("pending_after_commit", SW'(commit_pending), SW'(1));
      step(1'b0, 32'd0, 32'd0, 1'b1);
      for (int k = 0; k < NW; k++) begin
         slot_exp = (32'h3000_0000 + 32'(k)) & 32'h3FFF_FFFF;
         check("slot_value", SW'(snake[k*WW +: WW]), SW'(slot_exp[WW-1:0]));
      end
      check("fc_one", SW'(frame_count), SW'(16'd1));
      check("pending_cleared", SW'(commit_pending), SW'(0));

      // 3: write while pending is dropped and flagged; slot 3 keeps old value
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      step(1'b1, 32'd1003, 32'd5, 1'b0);
      check("overrun_set", SW'(overrun), SW'(1));
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1);
      check("slot3_kept", SW'(snake[3*WW +: WW]), SW'(30'h3000_0003));

      // Write landing in the copy cycle is still dropped
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      step(1'b1, 32'd1004, 32'h1234, 1'b1);
      check("slot4_kept", SW'(snake[4*WW +: WW]), SW'(30'h3000_0004));

      // 4: commit and frame_start together -> no same-cycle copy
      step(1'b1, 32'd1000, 32'h0ABC_DEF0, 1'b0);
      snap = snake;
      step(1'b1, 32'd1012, 32'd0, 1'b1);
      check("no_same_cycle_copy", SW'(snake), snap);
      idle();
      step(1'b0, 32'd0, 32'd0, 1'b1);
      check("slot0_updated", SW'(snake[0 +: WW]), SW'(30'h0ABC_DEF0));

      // 5: out-of-range strobes and a non-strobe commit address
      step(1'b1, 32'd999, 32'h1111_1111, 1'b0);
      check("addr_err_low", SW'(addr_error), SW'(1));
      step(1'b1, 32'd1013, 32'h2222_2222, 1'b0);
      step(1'b0, 32'd1012, 32'd0, 1'b0);
      check("no_commit_no_strobe", SW'(commit_pending), SW'(0));
      step(1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 32'd1005, 32'h0555_0555, 1'b0);
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1);

      // 6: run frame_count up to 0xFFFF, then wrap to 0
      while (m_fc != 16'hFFFF) begin
         step(1'b1, 32'd1012, 32'd0, 1'b0);
         step(1'b0, 32'd0, 32'd0, 1'b1);
      end
      check("fc_ffff", SW'(frame_count), SW'(16'hFFFF));
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1);
      check("fc_wrap", SW'(frame_count), SW'(16'h0000));

      // Reset while pending discards the commit and clears the snake
      step(1'b1, 32'd1012, 32'd0, 1'b0);
      check("pending_before_reset", SW'(commit_pending), SW'(1));
      do_reset();
      check("reset_pending", SW'(commit_pending), SW'(0));
      check("reset_snake", SW'(snake), SW'(0));
      step(1'b0, 32'd0, 32'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
